vend_ctrl: RTL and testbench

Sequencing controller for the vending-machine datapath. Accumulates coin credit from the coin-acceptor pulses, decides when the purchase price is reached, and issues a one-cycle dispense strobe with the change amount. It also runs an optional cancel/refund path. It sits between the coin inputs and the dispense/change mechanisms and owns all purchase state.

---
 rtl/vend_ctrl.sv | 156 +++++++++++++++
 tb/tb_vend_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl -- vending-machine purchase sequencer.
//
// Accumulates coin credit, issues a one-cycle dispense strobe with the change
// amount once the item price is reached, and (optionally) refunds credit on a
// cancel request. All outputs come straight from flops.
//
// Optional feature macro: VEND_CANCEL_EN
//   defined   -> cancel_i is honoured and the REFUND state is reachable
//   undefined -> cancel_i is ignored; credit persists until a purchase or reset
//
// Parameters
//   PRICE     item price in cents (multiple of 5, 5 .. 2**CREDIT_W-26)
//   CREDIT_W  width of credit/change values
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   nickle_i        5-cent coin pulse (highest priority)
//   dime_i          10-cent coin pulse
//   quarter_i       25-cent coin pulse (lowest priority)
//   cancel_i        refund request pulse
//   credit_o        accumulated credit
//   busy_o          high in VEND/REFUND; coins and cancel are dropped
//   soda_o          one-cycle dispense strobe
//   change_o        change/refund amount, 0 unless change_valid_o
//   change_valid_o  one-cycle strobe qualifying change_o
//   state_o         current FSM state (debug visibility)
//
// Handshake: the coin inputs and cancel_i are single-cycle "valid" pulses with
// no backpressure; busy_o is the inverse of "ready" -- any pulse sampled while
// busy_o is high is discarded, so the upstream must hold off until it drops.
// change_valid_o is a one-cycle valid with no ready; change_o is meaningful
// only in that cycle.
// -----------------------------------------------------------------------------
module vend_ctrl #(
  parameter int PRICE    = 20,
  parameter int CREDIT_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                cancel_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic                soda_o,
  output logic [CREDIT_W-1:0] change_o,
  output logic                change_valid_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                soda_q, soda_d;
  logic                chg_vld_q, chg_vld_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] coin_val;
  logic                coin_seen;
  logic [CREDIT_W-1:0] sum;
  logic                cancel_take;

  // Fixed priority: only the highest-priority coin of a cycle is credited.
  always_comb begin
    coin_val = '0;
    if (nickle_i)       coin_val = CREDIT_W'(5);
    else if (dime_i)    coin_val = CREDIT_W'(10);
    else if (quarter_i) coin_val = CREDIT_W'(25);
  end

  assign coin_seen = nickle_i | dime_i | quarter_i;
  // PRICE bound guarantees credit (< PRICE) + 25 fits in CREDIT_W bits.
  assign sum = credit_q + coin_val;

`ifdef VEND_CANCEL_EN
  // In IDLE a lone cancel has nothing to refund, so it needs a coin with it.
  assign cancel_take = cancel_i &&
                       ((state_q == S_COLLECT) || ((state_q == S_IDLE) && coin_seen));
`else
  assign cancel_take = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = '0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel_take) begin
          // Refund wins over vend even if the same-cycle coin reaches PRICE.
          state_d  = S_REFUND;
          change_d = sum;
          credit_d = '0;
        end else if (coin_seen) begin
          if (sum >= PRICE_C) begin
            state_d  = S_VEND;
            change_d = sum - PRICE_C;
            credit_d = '0;
          end else begin
            state_d  = S_COLLECT;
            credit_d = sum;
          end
        end
      end
      S_VEND, S_REFUND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
    // Strobes are registered alongside the state they belong to.
    soda_d    = (state_d == S_VEND);
    chg_vld_d = (state_d == S_VEND) || (state_d == S_REFUND);
    busy_d    = chg_vld_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      change_q  <= '0;
      soda_q    <= 1'b0;
      chg_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      change_q  <= change_d;
      soda_q    <= soda_d;
      chg_vld_q <= chg_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign credit_o       = credit_q;
  assign change_o       = change_q;
  assign soda_o         = soda_q;
  assign change_valid_o = chg_vld_q;
  assign busy_o         = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl -- directed bench for vend_ctrl (PRICE=20, CREDIT_W=6).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge. Expectations follow VEND_CANCEL_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_vend_ctrl;

  localparam int W = 6;

  logic         clk_i;
  logic         rst_ni;
  logic         nickle_i, dime_i, quarter_i, cancel_i;
  logic [W-1:0] credit_o, change_o;
  logic         busy_o, soda_o, change_valid_o;
  logic [1:0]   state_o;

  int total = 0;
  int bad   = 0;

  vend_ctrl #(.PRICE(20), .CREDIT_W(W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .nickle_i       (nickle_i),
    .dime_i         (dime_i),
    .quarter_i      (quarter_i),
    .cancel_i       (cancel_i),
    .credit_o       (credit_o),
    .busy_o         (busy_o),
    .soda_o         (soda_o),
    .change_o       (change_o),
    .change_valid_o (change_valid_o),
    .state_o        (state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // one comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // all externally visible outputs at once
  task automatic chk_out(input string tag, input int cr, input int so,
                         input int cv, input int ch, input int bz);
    chk({tag, ".credit"}, 32'(credit_o), 32'(cr));
    chk({tag, ".soda"},   32'(soda_o), 32'(so));
    chk({tag, ".cvld"},   32'(change_valid_o), 32'(cv));
    chk({tag, ".change"}, 32'(change_o), 32'(ch));
    chk({tag, ".busy"},   32'(busy_o), 32'(bz));
  endtask

  // driver: present inputs for one rising edge, then sample just after it
  task automatic step(input logic n, input logic d, input logic q, input logic c);
    @(negedge clk_i);
    nickle_i  = n;
    dime_i    = d;
    quarter_i = q;
    cancel_i  = c;
    @(posedge clk_i);
    #1;
    nickle_i  = 1'b0;
    dime_i    = 1'b0;
    quarter_i = 1'b0;
    cancel_i  = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    nickle_i = 1'b0; dime_i = 1'b0; quarter_i = 1'b0; cancel_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.state", 32'(state_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // four nickels: 5, 10, 15, then vend with zero change
    step(1, 0, 0, 0); chk_out("n1", 5, 0, 0, 0, 0);
    step(1, 0, 0, 0); chk_out("n2", 10, 0, 0, 0, 0);
    step(1, 0, 0, 0); chk_out("n3", 15, 0, 0, 0, 0);
    step(1, 0, 0, 0); chk_out("n4_vend", 0, 1, 1, 0, 1);
    step(0, 0, 0, 0); chk_out("n4_after", 0, 0, 0, 0, 0);

    // dime then quarter: 10, then vend with 15 change
    step(0, 1, 0, 0); chk_out("d1", 10, 0, 0, 0, 0);
    step(0, 0, 1, 0); chk_out("dq_vend", 0, 1, 1, 15, 1);
    step(0, 0, 0, 0); chk_out("dq_after", 0, 0, 0, 0, 0);

    // single quarter from IDLE: change 5
    step(0, 0, 1, 0); chk_out("q_vend", 0, 1, 1, 5, 1);
    step(0, 0, 0, 0); chk_out("q_after", 0, 0, 0, 0, 0);

    // nickel and dime together: only the nickel counts
    step(1, 1, 0, 0); chk_out("nd_prio", 5, 0, 0, 0, 0);
    // dime and quarter together on top of 5: only the dime counts -> 15
    step(0, 1, 1, 0); chk_out("dq_prio", 15, 0, 0, 0, 0);
    // quarter completes: 40 - 20 = 20 change
    step(0, 0, 1, 0); chk_out("big_vend", 0, 1, 1, 20, 1);
    // coin while busy is dropped
    step(0, 1, 0, 0); chk_out("busy_drop", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0); chk_out("busy_drop2", 0, 0, 0, 0, 0);
    // back-to-back: coin at the next edge starts a new purchase
    step(1, 0, 0, 0); chk_out("b2b", 5, 0, 0, 0, 0);
    step(0, 1, 0, 0); chk_out("b2b2", 15, 0, 0, 0, 0);

    // cancel at credit 15
    step(0, 0, 0, 1);
`ifdef VEND_CANCEL_EN
    chk_out("cancel15", 0, 0, 1, 15, 1);
    step(0, 0, 0, 0); chk_out("cancel15_after", 0, 0, 0, 0, 0);
    // lone cancel in IDLE: nothing happens
    step(0, 0, 0, 1); chk_out("cancel_idle", 0, 0, 0, 0, 0);
    // rebuild 15, then cancel with a dime: refund 25, no vend
    step(0, 1, 0, 0); chk_out("re_d", 10, 0, 0, 0, 0);
    step(1, 0, 0, 0); chk_out("re_n", 15, 0, 0, 0, 0);
    step(0, 1, 0, 1); chk_out("cancel25", 0, 0, 1, 25, 1);
    step(0, 0, 0, 0); chk_out("cancel25_after", 0, 0, 0, 0, 0);
    // cancel with a coin from IDLE: refund the coin
    step(0, 1, 0, 1); chk_out("cancel_coin", 0, 0, 1, 10, 1);
    step(0, 0, 0, 0); chk_out("cancel_coin_after", 0, 0, 0, 0, 0);
`else
    chk_out("cancel15", 15, 0, 0, 0, 0);
    step(0, 0, 0, 0); chk_out("cancel15_after", 15, 0, 0, 0, 0);
    // cancel with a dime: ordinary purchase, 25 - 20 = 5 change
    step(0, 1, 0, 1); chk_out("cancel_d_vend", 0, 1, 1, 5, 1);
    step(0, 0, 0, 0); chk_out("cancel_d_after", 0, 0, 0, 0, 0);
    // lone cancel in IDLE: nothing happens
    step(0, 0, 0, 1); chk_out("cancel_idle", 0, 0, 0, 0, 0);
`endif

    // asynchronous reset at credit 10
    step(0, 1, 0, 0); chk_out("pre_rst", 10, 0, 0, 0, 0);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst.state", 32'(state_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 0, 0, 0); chk_out("post_rst", 0, 0, 0, 0, 0);

    // vend still works after reset
    step(0, 0, 1, 0); chk_out("post_rst_vend", 0, 1, 1, 5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
